// File: rtl/iomem_fabric.sv
// Single-master to N-slave iomem interconnect: decodes the address page, sequences
// one outstanding request, and aborts unmapped or hung accesses through a watchdog.
module iomem_fabric #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [7:0]  BASE_PAGE      = 8'h03,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic [3:0]                 m_wstrb,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  output logic                       err_irq,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESP} state_t;

  state_t                  state, next_state;
  logic [15:0]             watchdog;
  logic [7:0]              page;
  logic [NUM_SLAVES-1:0]   decode;
  logic [31:0]             sel_rdata;
  logic                    hit;
  logic                    expired;

  // Page offset wraps modulo 256, so pages below BASE_PAGE land far out of range.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    page   = m_addr[31:24] - BASE_PAGE;
    decode = '0;
    for (int i = 0; i < NUM_SLAVES; i++) decode[i] = (page == 8'(i));
  end

  // s_valid is one-hot in ACCESS, so it doubles as the read-data mux select.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (s_valid[i]) sel_rdata = sel_rdata | s_rdata[i*32 +: 32];
  end

  assign hit     = |(s_ready & s_valid);
  assign expired = (watchdog == 16'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (m_valid) next_state = (|decode) ? ACCESS : ERROR;
      ACCESS:  if (hit) next_state = RESP;
               else if (expired) next_state = ERROR;
      ERROR:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_wstrb   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      err_irq   <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
      watchdog  <= '0;
    end else begin
      m_ready <= 1'b0;
      err_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_addr   <= m_addr;
            s_wdata  <= m_wdata;
            s_wstrb  <= m_wstrb;
            s_valid  <= decode;
            watchdog <= '0;
          end
        end
        ACCESS: begin
          watchdog <= watchdog + 16'd1;
          // A ready on the final watchdog cycle still completes normally.
          if (hit) begin
            m_rdata <= sel_rdata;
            s_valid <= '0;
          end else if (expired) begin
            s_valid <= '0;
          end
        end
        ERROR: begin
          m_rdata  <= ERR_RDATA;
          err_irq  <= 1'b1;
          err_addr <= s_addr;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        RESP:    m_ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iomem_fabric.md
Name: iomem_fabric

Overview:
- Single-master to N-slave interconnect and transaction sequencer for the PicoSoC iomem bus.
- Sits between the picosoc iomem master port and the memory-mapped peripherals (gpio, audio, timer, video).
- Decodes the address page and registers each request toward exactly one slave.
- Returns that slave's rdata/ready to the master; a bus watchdog terminates hung or unmapped accesses with an error response and an IRQ pulse.

Parameters:
- NUM_SLAVES, 4, number of slave slots (1..16).
- BASE_PAGE, 8'h03, slot i decodes addr[31:24] == BASE_PAGE+i.
- TIMEOUT_CYCLES, 255, max cycles in ACCESS before watchdog abort (1..65535).
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on error.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- m_valid  in  1  master request valid.
- m_ready  out  1  one-cycle response strobe to master.
- m_wstrb  in  4  byte write strobes (0 = read).
- m_addr  in  32  request address.
- m_wdata  in  32  write data.
- m_rdata  out  32  read data, valid while m_ready=1.
- s_valid  out  NUM_SLAVES  one-hot per-slave request.
- s_ready  in  NUM_SLAVES  per-slave completion.
- s_wstrb  out  4  registered strobes, broadcast to all slaves.
- s_addr  out  32  registered address, broadcast.
- s_wdata  out  32  registered write data, broadcast.
- s_rdata  in  32*NUM_SLAVES  slave i read data on bits [32i+31:32i].
- err_irq  out  1  one-cycle pulse per error response.
- err_addr  out  32  address of the most recent error.
- err_count  out  8  saturating error counter.

Behaviour:
- Clock and reset: one clock domain, clk. resetn is asynchronous and active-low.
- Reset values: state=IDLE; m_ready=0, m_rdata=0, s_valid=0, s_wstrb=0, s_addr=0, s_wdata=0, err_irq=0, err_addr=0, err_count=0, watchdog=0.
- Reset mid-transaction aborts the transaction immediately. No response is issued.
- FSM states: IDLE, ACCESS, ERROR, RESP.
- IDLE:
  - When m_valid=1, latch m_addr/m_wdata/m_wstrb into s_addr/s_wdata/s_wstrb.
  - slot = m_addr[31:24] - BASE_PAGE, 8-bit unsigned.
  - If slot < NUM_SLAVES: set s_valid[slot]=1, clear watchdog, go to ACCESS.
  - Otherwise (unmapped, including pages below BASE_PAGE via wrap-around): go to ERROR.
- ACCESS:
  - s_valid one-hot and s_* outputs held stable; watchdog increments by 1 each cycle.
  - s_ready[slot]=1: capture that slot's s_rdata slice into m_rdata, clear s_valid, go to RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: clear s_valid, go to ERROR.
  - s_ready of non-selected slots is ignored.
  - Ready and timeout in the same cycle: ready wins (no error).
- ERROR: m_rdata=ERR_RDATA; err_irq=1 for this one cycle; err_addr=s_addr; err_count+=1, saturating at 255; go to RESP.
- RESP: m_ready=1 for exactly one cycle, m_rdata valid. Then m_ready=0, go to IDLE.
- m_rdata holds its value until the next capture. It is not cleared after RESP.
- Latency: m_valid sampled at edge 0 gives s_valid high after edge 0. If the slave responds in its first ACCESS cycle, m_ready is high after edge 2.
- Unmapped access: m_ready high after edge 2 (IDLE, ERROR, RESP).
- Timeout access: m_ready high after edge TIMEOUT_CYCLES+2.
- Only one transaction is outstanding at a time. Back-to-back: a request presented in the cycle after RESP is accepted at that edge.
- m_valid dropping during ACCESS violates protocol. The block still completes the transaction and pulses m_ready.
- s_ready arriving while not in ACCESS (e.g. a late response after timeout) is ignored.
- Writes follow the same flow; m_rdata is returned as captured but is don't-care to the master.

Test Plan:
1. Read, slot 1: m_addr=0x0400_0010, wstrb=0. Slave 1 asserts ready in its 3rd ACCESS cycle with rdata=0x1234_5678 -> s_valid=4'b0010 for 3 cycles; m_ready one pulse 4 cycles after acceptance; m_rdata=0x1234_5678; err_irq never set.
2. Write, slot 0: m_addr=0x0300_0000, wstrb=4'hF, wdata=0xA5A5_A5A5, slave ready immediately -> s_wdata=0xA5A5_A5A5 and s_wstrb=4'hF stable while s_valid=1; m_ready after edge 2.
3. Unmapped: m_addr=0x0200_0000, then m_addr=0x0700_0000 -> s_valid stays 0; each gives m_ready with m_rdata=0xDEAD_BEEF; err_irq pulses twice; err_addr=0x0700_0000; err_count=2.
4. Timeout, TIMEOUT_CYCLES=8, slot 2 never ready -> s_valid[2] high exactly 8 cycles; m_rdata=0xDEAD_BEEF; err_irq one pulse; a later s_ready[2] is ignored; the next access to slot 3 completes normally.
5. Boundary: slave ready on the exact timeout cycle -> normal response, err_count unchanged. Drive 260 unmapped accesses -> err_count saturates at 255.
6. Reset: assert resetn=0 mid-ACCESS (asynchronously, between edges) -> s_valid, m_ready and err_irq go 0 immediately; no m_ready pulse after release; the next request completes normally.
